ddr3_read_checker: RTL and testbench
====================================

// Module: ddr3_read_checker
// PURPOSE
//  Downstream consumer of the DDR3 core read-return path. Holds the expected data for each
//  READ issued by the exercise state machine and compares it with read_data on read_data_valid.
//  Keeps pass/fail counts and captures the first failing word.
//  Raises done/pass status for LEDs or a debug probe.
// PARAMETERS
//  DEPTH       4     expected-data FIFO entries (power of 2, >=2); max outstanding reads
//  BEATS       1     read_data_valid beats per READ command (1..8)
//  NUM_READS   2     reads to check before the block reports done (1..65535)
//  TIMEOUT_CYC 1024  watchdog limit in clk cycles (used only with RDCHK_TIMEOUT_EN)
// PORTS
//  clk              in   1   system clock, same domain as the DDR3 core local bus
//  rst              in   1   synchronous, active-low reset
//  exp_push         in   1   1-cycle pulse: READ command accepted; capture exp_data
//  exp_data         in   64  expected data for the READ being issued
//  read_data        in   64  DDR3 core read data
//  read_data_valid  in   1   read_data qualifier, one pulse per beat
//  wl_err           in   1   DDR3 core write-levelling error
//  pass_cnt         out  16  reads whose beats all matched; saturates at 16'hFFFF
//  fail_cnt         out  16  reads with >=1 mismatching beat, or unexpected reads; saturates
//  fail_data        out  64  read_data of the first mismatching beat
//  fail_exp         out  64  expected word paired with fail_data
//  seq_err          out  1   sticky: FIFO overflow (push when full) or underflow (valid when empty)
//  timeout          out  1   sticky: watchdog expired (0 when macro absent)
//  done             out  1   state is S_DONE or S_ERR
//  pass             out  1   done & fail_cnt==0 & !seq_err & !timeout & state!=S_ERR
// BEHAVIOUR
//  Reset (rst==0 at posedge clk): every output is 0, FIFO is empty, beat_cnt=0, state=S_IDLE.
//    Reset mid-run discards outstanding expectations.
//  FIFO:
//   - Pointers are log2(DEPTH)+1 bits wide. full/empty come from pointer MSB compare.
//   - A push while full is dropped and sets seq_err.
//   - Push and pop in the same cycle are both honoured, including when full or when empty+push.
//     In the empty+push case the pop sees the old (empty) head, which is an underflow.
//  Compare:
//   - On read_data_valid with the FIFO not empty, read_data is compared with the head word.
//   - A mismatch sets a per-read fail flag. On the first mismatch since reset, fail_data and
//     fail_exp are captured.
//   - beat_cnt increments per beat. On beat BEATS-1 the head pops, beat_cnt clears, and either
//     pass_cnt or fail_cnt increments once.
//   - Counters and captures update in the cycle after read_data_valid (1-cycle latency).
//  Underflow: read_data_valid with the FIFO empty increments fail_cnt, sets seq_err,
//    and makes no capture.
//  FSM states: S_IDLE, S_RUN, S_DONE, S_ERR.
//   - S_IDLE -> S_RUN on exp_push.
//   - S_RUN -> S_DONE when pass_cnt+fail_cnt reaches NUM_READS.
//   - Any state -> S_ERR on wl_err (highest priority).
//   - S_DONE and S_ERR hold until reset. Compares continue in S_DONE; counters stay saturating.
// CONFIGURATION
//  RDCHK_TIMEOUT_EN defined:
//   - A watchdog counter runs in S_RUN while the FIFO is not empty.
//   - It clears on each read_data_valid.
//   - When it reaches TIMEOUT_CYC-1: timeout<=1, state->S_ERR.
//  RDCHK_TIMEOUT_EN undefined: no counter is built; timeout is tied to 0.
// STRUCTURE
//  ddr3_defs.vh (shared include): DDR3 command codes (READ=4'b0001, WRITE=4'b0010, ...),
//    checker state encodings, default test addresses/data words.
//  Sub-module ddr3_exp_fifo: DEPTH x 64 synchronous FIFO with push/pop/full/empty/head.
//    The checker FSM, beat counter, counters and watchdog live in the top level.
// TESTING
//  1. Push 64'h0123456789ABCDEF, 64'hDEADBEEFAAAA5555; return the same data -> pass_cnt=2,
//     fail_cnt=0, done=1, pass=1.
//  2. Push 64'h0123456789ABCDEF; return 64'h0123456789ABCDEE -> fail_cnt=1,
//     fail_data=...CDEE, fail_exp=...CDEF, pass=0.
//  3. Push 5 words with no returns, DEPTH=4 -> seq_err=1 on the 5th push;
//     the first 4 are still checked in order.
//  4. Pulse read_data_valid with the FIFO empty -> fail_cnt=1, seq_err=1, fail_data unchanged (0).
//  5. BEATS=2, one push; beat0 matches, beat1 mismatches -> fail_cnt=1, single pop,
//     capture = beat1.
//  6. Assert wl_err mid-run -> state S_ERR, done=1, pass=0.
//     With RDCHK_TIMEOUT_EN: push and no return for TIMEOUT_CYC cycles -> timeout=1.
//     Without the macro, timeout stays 0.

Source files
------------

// File: rtl/ddr3_read_checker_pkg.sv
// Shared definitions for the DDR3 read-return checker: command codes,
// checker state encoding, default test words and a saturating increment.
package ddr3_read_checker_pkg;

    localparam int DW = 64;

    typedef enum logic [3:0] {
        CMD_NOP   = 4'b0000,
        CMD_READ  = 4'b0001,
        CMD_WRITE = 4'b0010
    } ddr3_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } chk_state_e;

    localparam logic [DW-1:0] TEST_WORD0 = 64'h0123456789ABCDEF;
    localparam logic [DW-1:0] TEST_WORD1 = 64'hDEADBEEFAAAA5555;
    localparam logic [27:0]   TEST_ADDR0 = 28'h0000100;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr3_exp_fifo.sv
// Expected-data FIFO, DEPTH x 64, one extra pointer bit for full/empty.
// Ports: clk_i, rst_i (sync active-low), push_i/data_i, pop_i, full_o, empty_o, head_o.
module ddr3_exp_fifo
    import ddr3_read_checker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so push-when-full
    // is accepted if it coincides with a real pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ddr3_read_checker.sv
// Checks DDR3 read returns against expected words queued at READ issue.
// Ports: clk_i, rst_i (sync active-low), exp_push_i/exp_data_i, read_data_i,
//   read_data_valid_i, wl_err_i; outputs pass/fail counts, first-fail capture,
//   seq_err_o, timeout_o, done_o, pass_o. Watchdog built only with RDCHK_TIMEOUT_EN.
module ddr3_read_checker
    import ddr3_read_checker_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int BEATS       = 1,
    parameter int NUM_READS   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          exp_push_i,
    input  logic [DW-1:0] exp_data_i,
    input  logic [DW-1:0] read_data_i,
    input  logic          read_data_valid_i,
    input  logic          wl_err_i,
    output logic [15:0]   pass_cnt_o,
    output logic [15:0]   fail_cnt_o,
    output logic [DW-1:0] fail_data_o,
    output logic [DW-1:0] fail_exp_o,
    output logic          seq_err_o,
    output logic          timeout_o,
    output logic          done_o,
    output logic          pass_o
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    chk_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          rd_fail_q, rd_fail_d;
    logic          cap_vld_q, cap_vld_d;
    logic [15:0]   pass_q, pass_d, fail_q, fail_d;
    logic [DW-1:0] fdata_q, fdata_d, fexp_q, fexp_d;
    logic          seq_q, seq_d;
    logic          timeout_q, wd_hit;

    logic          full, empty;
    logic [DW-1:0] head;
    logic          hit, underflow, mismatch, last_beat, overflow, read_fail;
    logic [16:0]   total;

    assign hit       = read_data_valid_i & ~empty;
    assign underflow = read_data_valid_i & empty;
    assign mismatch  = hit & (read_data_i != head);
    assign last_beat = hit & (beat_q == BW'(BEATS - 1));
    assign overflow  = exp_push_i & full & ~last_beat;
    assign read_fail = rd_fail_q | mismatch;
    assign total     = {1'b0, pass_q} + {1'b0, fail_q};

    ddr3_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (exp_push_i),
        .data_i  (exp_data_i),
        .pop_i   (last_beat),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_comb begin
        beat_d    = beat_q;
        rd_fail_d = rd_fail_q;
        cap_vld_d = cap_vld_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        fdata_d   = fdata_q;
        fexp_d    = fexp_q;
        seq_d     = seq_q;
        if (last_beat) begin
            beat_d    = '0;
            rd_fail_d = 1'b0;
            if (read_fail) fail_d = sat_inc(fail_q);
            else           pass_d = sat_inc(pass_q);
        end else if (hit) begin
            beat_d    = beat_q + 1'b1;
            rd_fail_d = read_fail;
        end
        if (mismatch && !cap_vld_q) begin
            cap_vld_d = 1'b1;
            fdata_d   = read_data_i;
            fexp_d    = head;
        end
        if (underflow) begin
            fail_d = sat_inc(fail_q);
            seq_d  = 1'b1;
        end
        if (overflow) seq_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (exp_push_i) state_d = S_RUN;
            S_RUN:  if (total >= 17'(NUM_READS)) state_d = S_DONE;
            default: state_d = state_q;
        endcase
        if (wd_hit)   state_d = S_ERR;
        if (wl_err_i) state_d = S_ERR;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            rd_fail_q <= 1'b0;
            cap_vld_q <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            fdata_q   <= '0;
            fexp_q    <= '0;
            seq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_fail_q <= rd_fail_d;
            cap_vld_q <= cap_vld_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            fdata_q   <= fdata_d;
            fexp_q    <= fexp_d;
            seq_q     <= seq_d;
        end
    end

`ifdef RDCHK_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_d;

    // Only an outstanding read in S_RUN can stall; any returned beat
    // proves the read path is alive.
    assign wd_hit = (state_q == S_RUN) && !empty &&
                    (wd_q == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q | wd_hit;
        if (read_data_valid_i)
            wd_d = '0;
        else if (state_q == S_RUN && !empty)
            wd_d = wd_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
`else
    // The watchdog limit has no effect without the watchdog.
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign wd_hit     = 1'b0;
    assign timeout_q  = 1'b0;
`endif

    assign pass_cnt_o  = pass_q;
    assign fail_cnt_o  = fail_q;
    assign fail_data_o = fdata_q;
    assign fail_exp_o  = fexp_q;
    assign seq_err_o   = seq_q;
    assign timeout_o   = timeout_q;
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign pass_o      = done_o && (fail_q == 16'd0) && !seq_q &&
                         !timeout_q && (state_q != S_ERR);

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Scoreboard bench for ddr3_read_checker: BEATS=1 instance checked through
// a result queue, plus a BEATS=2 instance for multi-beat reads.
module tb_ddr3_read_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        push, valid, wl_err;
    logic [63:0] exp_data, rdata;
    logic [15:0] pass_cnt, fail_cnt;
    logic [63:0] fail_data, fail_exp;
    logic        seq_err, timeout, done, pass;

    logic        push2, valid2;
    logic [63:0] exp_data2, rdata2;
    logic [15:0] pass_cnt2, fail_cnt2;
    logic [63:0] fail_data2, fail_exp2;
    logic        seq_err2, timeout2, done2, pass2;

    ddr3_read_checker #(
        .DEPTH(4), .BEATS(1), .NUM_READS(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .exp_push_i(push), .exp_data_i(exp_data),
        .read_data_i(rdata), .read_data_valid_i(valid),
        .wl_err_i(wl_err),
        .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
        .fail_data_o(fail_data), .fail_exp_o(fail_exp),
        .seq_err_o(seq_err), .timeout_o(timeout),
        .done_o(done), .pass_o(pass)
    );

    ddr3_read_checker #(
        .DEPTH(4), .BEATS(2), .NUM_READS(2), .TIMEOUT_CYC(16)
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .exp_push_i(push2), .exp_data_i(exp_data2),
        .read_data_i(rdata2), .read_data_valid_i(valid2),
        .wl_err_i(1'b0),
        .pass_cnt_o(pass_cnt2), .fail_cnt_o(fail_cnt2),
        .fail_data_o(fail_data2), .fail_exp_o(fail_exp2),
        .seq_err_o(seq_err2), .timeout_o(timeout2),
        .done_o(done2), .pass_o(pass2)
    );

`ifdef RDCHK_TIMEOUT_EN
    localparam logic TMO = 1'b1;
`else
    localparam logic TMO = 1'b0;
`endif

    localparam logic [63:0] WA = 64'h0123456789ABCDEF;
    localparam logic [63:0] WB = 64'hDEADBEEFAAAA5555;
    localparam logic [63:0] WBAD = 64'h0123456789ABCDEE;

    typedef struct {
        logic [15:0] p;
        logic [15:0] f;
        logic [63:0] fd;
        logic [63:0] fe;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] prev_p = '0;
    logic [15:0] prev_f = '0;
    logic [63:0] w [5];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every change of the result counters consumes one expectation.
    always @(negedge clk) begin
        if (rst && (pass_cnt != prev_p || fail_cnt != prev_f)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected pass=%0d fail=%0d",
                         pass_cnt, fail_cnt);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_pass_cnt", 64'(pass_cnt), 64'(mon_e.p));
                chk("sb_fail_cnt", 64'(fail_cnt), 64'(mon_e.f));
                chk("sb_fail_data", fail_data, mon_e.fd);
                chk("sb_fail_exp", fail_exp, mon_e.fe);
            end
            prev_p = pass_cnt;
            prev_f = fail_cnt;
        end
    end

    function automatic exp_t mk(input int p, input int f,
                                input logic [63:0] fd,
                                input logic [63:0] fe);
        exp_t e;
        e.p = 16'(p); e.f = 16'(f); e.fd = fd; e.fe = fe;
        return e;
    endfunction

    task automatic do_reset();
        repeat (2) @(negedge clk);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        sbq.delete();
        rst = 1'b0;
        push = 0; valid = 0; wl_err = 0; push2 = 0; valid2 = 0;
        repeat (2) @(negedge clk);
        prev_p = '0;
        prev_f = '0;
        rst = 1'b1;
    endtask

    task automatic push_w(input logic [63:0] d);
        @(negedge clk);
        push = 1'b1; exp_data = d;
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic ret_w(input logic [63:0] d, input exp_t e);
        sbq.push_back(e);
        @(negedge clk);
        valid = 1'b1; rdata = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic beat2(input logic [63:0] d);
        @(negedge clk);
        valid2 = 1'b1; rdata2 = d;
        @(negedge clk);
        valid2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b0;
        push = 0; valid = 0; wl_err = 0; exp_data = '0; rdata = '0;
        push2 = 0; valid2 = 0; exp_data2 = '0; rdata2 = '0;
        w[0] = 64'h1111; w[1] = 64'h2222; w[2] = 64'h3333;
        w[3] = 64'h4444; w[4] = 64'h5555;
        repeat (3) @(negedge clk);
        chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        chk("rst_fail_cnt", 64'(fail_cnt), 64'd0);
        chk("rst_fail_data", fail_data, 64'd0);
        chk("rst_flags", 64'({seq_err, timeout, done, pass}), 64'd0);
        rst = 1'b1;

        // Two matching reads complete the run.
        push_w(WA);
        push_w(WB);
        ret_w(WA, mk(1, 0, 0, 0));
        ret_w(WB, mk(2, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_pass", 64'(pass), 64'd1);

        // Single mismatch captured.
        do_reset();
        push_w(WA);
        ret_w(WBAD, mk(0, 1, WBAD, WA));
        repeat (2) @(negedge clk);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_done", 64'(done), 64'd0);

        // Overflow: fifth push dropped, first four checked in order.
        do_reset();
        for (int i = 0; i < 4; i++) push_w(w[i]);
        chk("t3_seq_pre", 64'(seq_err), 64'd0);
        push_w(w[4]);
        chk("t3_seq_ovf", 64'(seq_err), 64'd1);
        for (int i = 0; i < 4; i++) ret_w(w[i], mk(i + 1, 0, 0, 0));
        ret_w(w[4], mk(4, 1, 0, 0));
        repeat (2) @(negedge clk);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_pass", 64'(pass), 64'd0);

        // Underflow on empty FIFO.
        do_reset();
        ret_w(64'hFFFF_FFFF_FFFF_FFFF, mk(0, 1, 0, 0));
        repeat (2) @(negedge clk);
        chk("t4_seq_err", 64'(seq_err), 64'd1);
        chk("t4_done", 64'(done), 64'd0);

        // Push and pop together while full is not an overflow.
        do_reset();
        for (int i = 0; i < 4; i++) push_w(w[i]);
        sbq.push_back(mk(1, 0, 0, 0));
        @(negedge clk);
        push = 1'b1; exp_data = w[4]; valid = 1'b1; rdata = w[0];
        @(negedge clk);
        push = 1'b0; valid = 1'b0;
        chk("t7_seq_full_pp", 64'(seq_err), 64'd0);
        for (int i = 1; i < 5; i++) ret_w(w[i], mk(i + 1, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("t7_pass", 64'(pass), 64'd1);

        // Write-levelling error forces S_ERR.
        do_reset();
        push_w(WA);
        ret_w(WA, mk(1, 0, 0, 0));
        @(negedge clk);
        wl_err = 1'b1;
        @(negedge clk);
        wl_err = 1'b0;
        @(negedge clk);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_pass", 64'(pass), 64'd0);

        // Stalled read: watchdog only when built in.
        do_reset();
        push_w(WA);
        repeat (24) @(negedge clk);
        chk("t6_timeout", 64'(timeout), 64'(TMO));
        chk("t6_tmo_done", 64'(done), 64'(TMO));

        // Two-beat read: mismatch on beat 1, then a clean read.
        do_reset();
        @(negedge clk);
        push2 = 1'b1; exp_data2 = WA;
        @(negedge clk);
        push2 = 1'b0;
        beat2(WA);
        chk("t5_mid_cnt", 64'({pass_cnt2, fail_cnt2}), 64'd0);
        beat2(WA ^ 64'd1);
        chk("t5_fail_cnt", 64'(fail_cnt2), 64'd1);
        chk("t5_pass_cnt", 64'(pass_cnt2), 64'd0);
        chk("t5_fail_data", fail_data2, WA ^ 64'd1);
        chk("t5_fail_exp", fail_exp2, WA);
        @(negedge clk);
        push2 = 1'b1; exp_data2 = WB;
        @(negedge clk);
        push2 = 1'b0;
        beat2(WB);
        beat2(WB);
        chk("t5_second_pass", 64'(pass_cnt2), 64'd1);
        chk("t5_seq_err", 64'(seq_err2), 64'd0);
        repeat (2) @(negedge clk);
        chk("t5_done", 64'(done2), 64'd1);

        repeat (2) @(negedge clk);
        chk("sb_final_drain", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
